// File: rtl/microwave_pkg.sv
// Shared state encodings, preset limits and the preset saturation helper
// for the microwave cooking sequencer.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COOK   = 2'd1,
        ST_PAUSED = 2'd2,
        ST_BEEP   = 2'd3
    } state_t;

    localparam logic [6:0] MAX_SEC    = 7'd59;
    localparam logic [6:0] MAX_MIN    = 7'd99;
    localparam logic [6:0] QUICK_SEC  = 7'd30;
    localparam logic [3:0] MAX_POWER  = 4'd10;
    localparam logic [3:0] PHASE_LAST = 4'd9;

    function automatic logic [6:0] sat7(input logic [6:0] value, input logic [6:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: free-running 0..TICK_COUNT-1 with a one-cycle tick
// strobe on the last count; restart forces the count back to zero.
module tick_gen #(
    parameter int TICK_COUNT = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (restart || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/microwave_ctrl.sv
// Cooking sequencer: presets and start/pause/stop pulses toward the countdown
// timer, plus magnetron duty cycle, cavity lamp, end-of-cook beep and arm fault.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_COUNT  = 50_000_000,
    parameter int BEEP_TICKS  = 3,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       door_open,
    input  logic [6:0] min_in,
    input  logic [6:0] sec_in,
    input  logic [3:0] power,
    input  logic       timer_done,
    output logic [6:0] min_out,
    output logic [6:0] sec_out,
    output logic       timer_start,
    output logic       timer_pause,
    output logic       timer_stop,
    output logic       magnetron,
    output logic       lamp,
    output logic       beep,
    output logic       fault,
    output logic [1:0] state
);

    localparam int AW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIMEOUT - 1);
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    state_t        r_state, w_state_next;
    logic          r_armed, w_armed_next;
    logic [AW-1:0] r_arm_cnt, w_arm_cnt_next;
    logic          r_fault, w_fault_next;
    logic [BW-1:0] r_beep_cnt, w_beep_cnt_next;
    logic [3:0]    r_phase, w_phase_next;
    logic          r_door_q;
    logic          r_timer_start, r_timer_pause, r_timer_stop;
    logic          w_start_pulse, w_pause_pulse, w_stop_pulse;
    logic [6:0]    r_min_out, r_sec_out;
    logic [6:0]    w_min_sat, w_sec_sat, w_min_preset, w_sec_preset;
    logic          r_magnetron, r_lamp, r_beep;
    logic          w_tick, w_restart;
    logic [3:0]    w_eff_power;
    logic          w_door_rise, w_any_event;

    tick_gen #(
        .TICK_COUNT(TICK_COUNT)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .restart(w_restart),
        .tick   (w_tick)
    );

    assign w_min_sat    = sat7(min_in, MAX_MIN);
    assign w_sec_sat    = sat7(sec_in, MAX_SEC);
    assign w_min_preset = w_min_sat;
    assign w_sec_preset = ((w_min_sat == 7'd0) && (w_sec_sat == 7'd0)) ? QUICK_SEC : w_sec_sat;
    assign w_eff_power  = (power > MAX_POWER) ? MAX_POWER : power;
    assign w_door_rise  = door_open & ~r_door_q;
    assign w_any_event  = btn_start | btn_stop | btn_pause | w_door_rise;

    // Stop outranks the door, the door outranks pause, pause outranks start.
    always_comb begin
        w_state_next    = r_state;
        w_armed_next    = r_armed;
        w_arm_cnt_next  = r_arm_cnt;
        w_fault_next    = r_fault;
        w_beep_cnt_next = r_beep_cnt;
        w_start_pulse   = 1'b0;
        w_pause_pulse   = 1'b0;
        w_stop_pulse    = 1'b0;
        w_restart       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_start && !btn_stop && !door_open && !btn_pause) begin
                    w_state_next   = ST_COOK;
                    w_start_pulse  = 1'b1;
                    w_restart      = 1'b1;
                    w_armed_next   = 1'b0;
                    w_arm_cnt_next = '0;
                    w_fault_next   = 1'b0;
                end
            end
            ST_COOK: begin
                if (btn_stop) begin
                    w_state_next = ST_IDLE;
                    w_stop_pulse = 1'b1;
                end else if (door_open || btn_pause) begin
                    w_state_next  = ST_PAUSED;
                    w_pause_pulse = 1'b1;
                end else if (r_armed && timer_done) begin
                    w_state_next    = ST_BEEP;
                    w_beep_cnt_next = '0;
                end else if (!r_armed) begin
                    if (!timer_done) begin
                        w_armed_next = 1'b1;
                    end else if (r_arm_cnt == ARM_LAST) begin
                        w_state_next = ST_IDLE;
                        w_stop_pulse = 1'b1;
                        w_fault_next = 1'b1;
                    end else begin
                        w_arm_cnt_next = r_arm_cnt + 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (btn_stop) begin
                    w_state_next = ST_IDLE;
                    w_stop_pulse = 1'b1;
                end else if (btn_start && !door_open && !btn_pause) begin
                    // Arm flag is kept: the timer already left idle before the pause.
                    w_state_next  = ST_COOK;
                    w_start_pulse = 1'b1;
                    w_fault_next  = 1'b0;
                end
            end
            ST_BEEP: begin
                if (w_any_event) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (r_beep_cnt == BEEP_LAST) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_beep_cnt_next = r_beep_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_phase_next = 4'd0;
        case (r_state)
            ST_COOK: begin
                w_phase_next = r_phase;
                if (w_tick) begin
                    w_phase_next = (r_phase == PHASE_LAST) ? 4'd0 : r_phase + 4'd1;
                end
            end
            ST_PAUSED: w_phase_next = r_phase;
            default:   w_phase_next = 4'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_armed       <= 1'b0;
            r_arm_cnt     <= '0;
            r_fault       <= 1'b0;
            r_beep_cnt    <= '0;
            r_phase       <= 4'd0;
            r_door_q      <= 1'b0;
            r_timer_start <= 1'b0;
            r_timer_pause <= 1'b0;
            r_timer_stop  <= 1'b0;
            r_min_out     <= 7'd0;
            r_sec_out     <= 7'd0;
            r_magnetron   <= 1'b0;
            r_lamp        <= 1'b0;
            r_beep        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_armed       <= w_armed_next;
            r_arm_cnt     <= w_arm_cnt_next;
            r_fault       <= w_fault_next;
            r_beep_cnt    <= w_beep_cnt_next;
            r_phase       <= w_phase_next;
            r_door_q      <= door_open;
            r_timer_start <= w_start_pulse;
            r_timer_pause <= w_pause_pulse;
            r_timer_stop  <= w_stop_pulse;
            if (r_state == ST_IDLE) begin
                r_min_out <= w_min_preset;
                r_sec_out <= w_sec_preset;
            end
            r_magnetron <= (r_state == ST_COOK) && !door_open && (r_phase < w_eff_power);
            r_lamp      <= door_open || (r_state == ST_COOK) || (r_state == ST_PAUSED);
            r_beep      <= (w_state_next == ST_BEEP);
        end
    end

    assign min_out     = r_min_out;
    assign sec_out     = r_sec_out;
    assign timer_start = r_timer_start;
    assign timer_pause = r_timer_pause;
    assign timer_stop  = r_timer_stop;
    assign magnetron   = r_magnetron;
    assign lamp        = r_lamp;
    assign beep        = r_beep;
    assign fault       = r_fault;
    assign state       = r_state;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed-plus-random bench for microwave_ctrl with a small arithmetic
// reference model for presets, duty cycle and beep duration.
module tb_microwave_ctrl;

    localparam int TC = 4;
    localparam int BT = 3;
    localparam int AT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_pause = 1'b0;
    logic       door_open = 1'b0;
    logic [6:0] min_in = 7'd0, sec_in = 7'd0;
    logic [3:0] power = 4'd0;
    logic       timer_done = 1'b1;
    logic [6:0] min_out, sec_out;
    logic       timer_start, timer_pause, timer_stop;
    logic       magnetron, lamp, beep, fault;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    microwave_ctrl #(
        .TICK_COUNT (TC),
        .BEEP_TICKS (BT),
        .ARM_TIMEOUT(AT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_pause  (btn_pause),
        .door_open  (door_open),
        .min_in     (min_in),
        .sec_in     (sec_in),
        .power      (power),
        .timer_done (timer_done),
        .min_out    (min_out),
        .sec_out    (sec_out),
        .timer_start(timer_start),
        .timer_pause(timer_pause),
        .timer_stop (timer_stop),
        .magnetron  (magnetron),
        .lamp       (lamp),
        .beep       (beep),
        .fault      (fault),
        .state      (state)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic s, input logic p, input logic t);
        btn_start = s;
        btn_pause = p;
        btn_stop  = t;
        step();
        btn_start = 1'b0;
        btn_pause = 1'b0;
        btn_stop  = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int n);
        n = 0;
        while (state !== s && n < limit) begin
            step();
            n++;
        end
    endtask

    // Reference model: clamp each field, then quick cook if both clamp to zero.
    function automatic int model_min(input int m, input int s);
        return (m > 99) ? 99 : m;
    endfunction

    function automatic int model_sec(input int m, input int s);
        int mm, ss;
        mm = (m > 99) ? 99 : m;
        ss = (s > 59) ? 59 : s;
        return (mm == 0 && ss == 0) ? 30 : ss;
    endfunction

    // Ten phases per duty period, each lasting one tick of TC cycles.
    function automatic int model_on_cycles(input int p);
        return TC * ((p > 10) ? 10 : p);
    endfunction

    initial begin
        int n, on_cnt, m, s;
        logic beep_ok;
        int powers[4];

        // Reset state, door held open to prove the lamp is also cleared.
        door_open = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {min_out, sec_out, timer_start, timer_pause, timer_stop,
                              magnetron, lamp, beep, fault, state}, 0);
        door_open = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("first_idle_min", min_out, 0);
        chk("first_idle_sec", sec_out, 30);

        // Quick cook through to beep and back to idle.
        press(1'b1, 1'b0, 1'b0);
        chk("quick_start_pulse", timer_start, 1);
        chk("quick_state_cook", state, 1);
        timer_done = 1'b0;
        step();
        chk("quick_start_one_cycle", timer_start, 0);
        repeat (5) step();
        timer_done = 1'b1;
        wait_state(2'd3, 10, n);
        chk("quick_reach_beep", (n < 10), 1);
        beep_ok = 1'b1;
        n = 0;
        while (state === 2'd3 && n < 40) begin
            if (beep !== 1'b1) beep_ok = 1'b0;
            step();
            n++;
        end
        chk("quick_beep_high", beep_ok, 1);
        chk("quick_beep_len", (n >= (BT - 1) * TC + 1) && (n <= BT * TC), 1);
        chk("quick_back_idle", state, 0);
        chk("quick_beep_off", beep, 0);

        // Saturation: fixed corners then random entries.
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin m = 120; s = 75; end
                1: begin m = 0;   s = 75; end
                2: begin m = 120; s = 0;  end
                default: begin m = $urandom_range(0, 127); s = $urandom_range(0, 127); end
            endcase
            min_in = 7'(m);
            sec_in = 7'(s);
            step();
            step();
            chk($sformatf("preset_min_%0d_%0d", m, s), min_out, model_min(m, s));
            chk($sformatf("preset_sec_%0d_%0d", m, s), sec_out, model_sec(m, s));
        end
        min_in = 7'd120;
        sec_in = 7'd75;
        step();
        press(1'b1, 1'b0, 1'b0);
        timer_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            min_in = 7'($urandom_range(0, 127));
            sec_in = 7'($urandom_range(0, 127));
            step();
            chk("frozen_min", min_out, 99);
            chk("frozen_sec", sec_out, 59);
        end
        press(1'b0, 1'b0, 1'b1);
        chk("stop_pulse", timer_stop, 1);
        chk("stop_idle", state, 0);
        timer_done = 1'b1;
        step();

        // Duty cycle over ten ticks at several power levels.
        powers[0] = 3;
        powers[1] = 0;
        powers[2] = 15;
        powers[3] = $urandom_range(0, 15);
        for (int i = 0; i < 4; i++) begin
            power = 4'(powers[i]);
            press(1'b1, 1'b0, 1'b0);
            chk("duty_cook", state, 1);
            timer_done = 1'b0;
            on_cnt = 0;
            for (int c = 0; c < 10 * TC; c++) begin
                step();
                if (magnetron === 1'b1) on_cnt++;
            end
            chk($sformatf("duty_power_%0d", powers[i]), on_cnt, model_on_cycles(powers[i]));
            chk("duty_lamp", lamp, 1);
            press(1'b0, 1'b0, 1'b1);
            timer_done = 1'b1;
            step();
        end

        // Door during cook, ignored start, resume keeps the phase.
        power = 4'd1;
        press(1'b1, 1'b0, 1'b0);
        timer_done = 1'b0;
        step();
        chk("door_mag_phase0", magnetron, 1);
        repeat (5) step();
        door_open = 1'b1;
        step();
        chk("door_pause_pulse", timer_pause, 1);
        chk("door_paused", state, 2);
        step();
        chk("door_mag_off", magnetron, 0);
        chk("door_lamp", lamp, 1);
        press(1'b1, 1'b0, 1'b0);
        chk("door_start_ignored_state", state, 2);
        chk("door_start_ignored_pulse", timer_start, 0);
        door_open = 1'b0;
        step();
        press(1'b1, 1'b0, 1'b0);
        chk("resume_pulse", timer_start, 1);
        chk("resume_cook", state, 1);
        on_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (magnetron === 1'b1) on_cnt++;
        end
        chk("resume_phase_kept", on_cnt, 0);
        press(1'b0, 1'b0, 1'b1);

        // Beep ended early by a button.
        press(1'b1, 1'b0, 1'b0);
        repeat (2) step();
        timer_done = 1'b1;
        wait_state(2'd3, 10, n);
        chk("early_reach_beep", (n < 10), 1);
        press(1'b0, 1'b1, 1'b0);
        chk("early_idle", state, 0);
        chk("early_beep_off", beep, 0);
        chk("early_no_pulse", timer_pause, 0);

        // Arm failure with timer_done stuck high.
        press(1'b1, 1'b0, 1'b0);
        n = 0;
        while (fault !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("arm_timeout_cycles", n, AT);
        chk("arm_stop_pulse", timer_stop, 1);
        chk("arm_idle", state, 0);
        step();
        chk("arm_stop_one_cycle", timer_stop, 0);
        chk("arm_fault_sticky", fault, 1);
        press(1'b1, 1'b0, 1'b0);
        chk("arm_fault_cleared", fault, 0);
        timer_done = 1'b0;
        step();

        // Pause, then start and stop together: stop wins.
        press(1'b0, 1'b1, 1'b0);
        chk("pause_btn_state", state, 2);
        chk("pause_btn_pulse", timer_pause, 1);
        press(1'b1, 1'b0, 1'b1);
        chk("both_stop_pulse", timer_stop, 1);
        chk("both_no_start", timer_start, 0);
        chk("both_idle", state, 0);
        timer_done = 1'b1;
        step();

        // Asynchronous reset in the middle of a cook.
        power = 4'd10;
        press(1'b1, 1'b0, 1'b0);
        timer_done = 1'b0;
        repeat (3) step();
        chk("pre_reset_mag", magnetron, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {min_out, sec_out, timer_start, timer_pause, timer_stop,
                                    magnetron, lamp, beep, fault, state}, 0);
        step();
        reset = 1'b1;
        timer_done = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
